// File: rtl/hd_stream_accum.sv
// hd_stream_accum: two-stage valid/ready Hamming(7,4) pair decoder feeding a saturating frame accumulator.
// Define HD_ERR_STAT_EN to add the clr_stat input and the err_cnt corrected-word counter.
module hd_stream_accum #(
  parameter int FRAME_LEN = 8,
  parameter int ACC_W     = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [6:0]              code_word1,
  input  logic [6:0]              code_word2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [5:0]       out_n,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_last,
  output logic                    out_sat
`ifdef HD_ERR_STAT_EN
  ,
  input  logic                    clr_stat,
  output logic [15:0]             err_cnt
`endif
);
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  function automatic logic [2:0] syndrome(input logic [6:0] cw);
    return {cw[6] ^ cw[3] ^ cw[2] ^ cw[1],
            cw[5] ^ cw[3] ^ cw[2] ^ cw[0],
            cw[4] ^ cw[3] ^ cw[1] ^ cw[0]};
  endfunction

  // Returns {corrected info[3:0], received value of the flagged bit}.
  function automatic logic [4:0] decode_word(input logic [6:0] cw);
    logic [3:0] info;
    logic       wb;
    info = cw[3:0];
    wb   = 1'b0;
    case (syndrome(cw))
      3'b001:  wb = cw[4];
      3'b010:  wb = cw[5];
      3'b100:  wb = cw[6];
      3'b011:  begin wb = cw[0]; info[0] = ~cw[0]; end
      3'b101:  begin wb = cw[1]; info[1] = ~cw[1]; end
      3'b110:  begin wb = cw[2]; info[2] = ~cw[2]; end
      3'b111:  begin wb = cw[3]; info[3] = ~cw[3]; end
      default: wb = 1'b0;
    endcase
    return {info, wb};
  endfunction

  logic                    en;
  logic                    s1_valid;
  logic [3:0]              s1_a;
  logic [3:0]              s1_b;
  logic [1:0]              s1_opt;
  logic [4:0]              dec_a;
  logic [4:0]              dec_b;
  logic signed [5:0]       a6;
  logic signed [5:0]       b6;
  logic signed [5:0]       n_next;
  logic signed [ACC_W:0]   sum_wide;
  logic signed [ACC_W-1:0] sum_sat;
  logic                    sat_hit;
  logic signed [ACC_W-1:0] acc_reg;
  logic                    frame_sat_reg;
  logic [CNT_W-1:0]        beat_cnt;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign dec_a    = decode_word(code_word1);
  assign dec_b    = decode_word(code_word2);

  always_comb begin
    a6 = {{2{s1_a[3]}}, s1_a};
    b6 = {{2{s1_b[3]}}, s1_b};
    case (s1_opt)
      2'b00:   n_next = a6 + a6 + b6;
      2'b01:   n_next = a6 + a6 - b6;
      2'b10:   n_next = a6 - b6 - b6;
      default: n_next = a6 + b6 + b6;
    endcase
    // One guard bit: overflow shows as disagreement between the top two bits.
    sum_wide = {acc_reg[ACC_W-1], acc_reg} + {{(ACC_W-5){n_next[5]}}, n_next};
    sat_hit  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (!sat_hit)
      sum_sat = sum_wide[ACC_W-1:0];
    else if (sum_wide[ACC_W])
      sum_sat = ACC_MIN;
    else
      sum_sat = ACC_MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_a          <= '0;
      s1_b          <= '0;
      s1_opt        <= '0;
      out_valid     <= 1'b0;
      out_n         <= '0;
      out_sum       <= '0;
      out_last      <= 1'b0;
      out_sat       <= 1'b0;
      acc_reg       <= '0;
      frame_sat_reg <= 1'b0;
      beat_cnt      <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (in_valid) begin
        s1_a   <= dec_a[4:1];
        s1_b   <= dec_b[4:1];
        s1_opt <= {dec_a[0], dec_b[0]};
      end
      if (s1_valid) begin
        out_n    <= n_next;
        out_sum  <= sum_sat;
        out_sat  <= frame_sat_reg | sat_hit;
        out_last <= (beat_cnt == LAST_BEAT);
        // Closing beat of a frame: the next beat starts from a clean accumulator.
        if (beat_cnt == LAST_BEAT) begin
          beat_cnt      <= '0;
          acc_reg       <= '0;
          frame_sat_reg <= 1'b0;
        end else begin
          beat_cnt      <= beat_cnt + 1'b1;
          acc_reg       <= sum_sat;
          frame_sat_reg <= frame_sat_reg | sat_hit;
        end
      end
    end
  end

`ifdef HD_ERR_STAT_EN
  logic [1:0]  s1_err;
  logic [16:0] err_sum;

  assign err_sum = {1'b0, err_cnt} + {15'd0, s1_err};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_err  <= '0;
      err_cnt <= '0;
    end else begin
      if (en && in_valid)
        s1_err <= {1'b0, |syndrome(code_word1)} + {1'b0, |syndrome(code_word2)};
      if (clr_stat)
        err_cnt <= '0;
      else if (en && s1_valid)
        err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end
`endif

endmodule
